// File: rtl/nibble_serial_addsub_ctrl.sv
// Serial WIDTH-bit add/subtract controller: one shared SLICE-bit adder is reused once per
// slice, LSB slice first, with the inter-slice carry held in a register.
module nibble_serial_addsub_ctrl #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             C_out,
    output logic             busy
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             c_out_q, c_out_d;

    logic [SLICE-1:0] a_slice, b_slice, slice_sum;
    logic             slice_co;
    logic             last_slice;

    // The single shared adder slice.
    assign a_slice                = opa_q[cnt_q*SLICE +: SLICE];
    assign b_slice                = opb_q[cnt_q*SLICE +: SLICE];
    assign {slice_co, slice_sum}  = {1'b0, a_slice} + {1'b0, b_slice}
                                  + {{SLICE{1'b0}}, carry_q};
    assign last_slice             = (cnt_q == CW'(NSLICE - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        carry_d = carry_q;
        d_d     = d_q;
        c_out_d = c_out_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    // Subtraction as A + ~B + 1: invert B once here, force carry-in.
                    opa_d   = A;
                    opb_d   = op ? ~B : B;
                    carry_d = op;
                    cnt_d   = '0;
                    d_d     = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                d_d[cnt_q*SLICE +: SLICE] = slice_sum;
                carry_d                   = slice_co;
                if (last_slice) begin
                    c_out_d = slice_co;
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            carry_q <= 1'b0;
            d_q     <= '0;
            c_out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            carry_q <= carry_d;
            d_q     <= d_d;
            c_out_q <= c_out_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign D         = d_q;
    assign C_out     = c_out_q;

endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Directed and randomized bench for nibble_serial_addsub_ctrl; results are compared with a
// plain 17-bit arithmetic model of A + (op ? ~B : B) + op.
module tb_nibble_serial_addsub_ctrl;

    localparam int unsigned W  = 16;
    localparam int unsigned NS = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         op;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] D;
    logic         C_out;
    logic         busy;

    int errors = 0;
    int checks = 0;

    nibble_serial_addsub_ctrl #(.WIDTH(W), .SLICE(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .A        (A),
        .B        (B),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .D        (D),
        .C_out    (C_out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic o, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
        logic [W-1:0] bb;
        bb = o ? ~b : b;
        return {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, o};
    endfunction

    // Present a request and hold it until the accept edge has passed.
    task automatic launch(input string tag, input logic o, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        int n;
        in_valid = 1'b1;
        op       = o;
        A        = a;
        B        = b;
        n        = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        if (!in_ready) chk({tag, "_accept_timeout"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    // Walk the NS calc cycles after the accept edge, optionally scrambling operands.
    task automatic wait_result(input string tag, input bit scramble);
        for (int k = 1; k <= NS; k++) begin
            if (scramble) begin
                A  = W'($urandom);
                B  = W'($urandom);
                op = 1'($urandom);
            end
            step();
            if (k < NS) begin
                chk({tag, "_early_valid"}, 32'(out_valid), 32'd0);
                chk({tag, "_calc_ready"}, 32'(in_ready), 32'd0);
            end else begin
                chk({tag, "_latency_valid"}, 32'(out_valid), 32'd1);
            end
        end
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] exp_d,
                                input logic exp_c);
        chk({tag, "_D"}, 32'(D), 32'(exp_d));
        chk({tag, "_C_out"}, 32'(C_out), 32'(exp_c));
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_drain_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_d,
                          input logic exp_c);
        launch(tag, o, a, b);
        wait_result(tag, 1'b0);
        check_result(tag, exp_d, exp_c);
        drain(tag);
    endtask

    initial begin
        logic [W:0]   m;
        logic [W-1:0] ra, rb;
        logic         ro;
        int           hold;

        rst       = 1'b1;
        in_valid  = 1'b0;
        op        = 1'b0;
        A         = '0;
        B         = '0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_D", 32'(D), 32'd0);
        chk("reset_C_out", 32'(C_out), 32'd0);

        // Basic add with latency and busy observation.
        launch("add1", 1'b0, 16'h1234, 16'h0FFF);
        chk("add1_busy", 32'(busy), 32'd1);
        wait_result("add1", 1'b0);
        check_result("add1", 16'h2233, 1'b0);
        drain("add1");

        run_op("add_ripple", 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
        run_op("add_msb", 1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1);
        run_op("sub1", 1'b1, 16'h5000, 16'h0001, 16'h4FFF, 1'b1);
        run_op("sub_borrow", 1'b1, 16'h0001, 16'h0002, 16'hFFFF, 1'b0);
        run_op("sub_equal", 1'b1, 16'hABCD, 16'hABCD, 16'h0000, 1'b1);

        // Backpressure with a pending request waiting in DONE.
        launch("bp", 1'b0, 16'h1111, 16'h2222);
        wait_result("bp", 1'b0);
        in_valid = 1'b1;
        op       = 1'b1;
        A        = 16'h0100;
        B        = 16'h0001;
        for (int k = 0; k < 3; k++) begin
            step();
            check_result("bp_hold", 16'h3333, 1'b0);
            chk("bp_hold_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_idle_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp_accepted", 32'(in_ready), 32'd0);
        wait_result("bp2", 1'b0);
        check_result("bp2", 16'h00FF, 1'b1);
        drain("bp2");

        // Operand changes during CALC must not disturb the result.
        launch("stable", 1'b0, 16'h00FF, 16'h0001);
        wait_result("stable", 1'b1);
        check_result("stable", 16'h0100, 1'b0);
        drain("stable");

        // Reset in the middle of CALC, at slice index 2.
        launch("rst_mid", 1'b0, 16'hFFFF, 16'hFFFF);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_ready", 32'(in_ready), 32'd1);
        chk("rst_mid_D", 32'(D), 32'd0);
        chk("rst_mid_C_out", 32'(C_out), 32'd0);
        run_op("after_rst", 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0);

        // Randomized operations against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            ro = 1'($urandom);
            if (i % 8 == 0) rb = ra;
            m = model(ro, ra, rb);
            launch("rnd", ro, ra, rb);
            wait_result("rnd", (i % 3) == 0);
            in_valid = 1'b0;
            hold = $urandom_range(0, 2);
            for (int k = 0; k < hold; k++) step();
            check_result("rnd", m[W-1:0], m[W]);
            drain("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
